// File: rtl/wshb_rr_arbiter.sv
// N-master to 1-slave Wishbone classic round-robin arbiter and mux for the shared SDRAM port.
// Define WSHB_ARB_PREEMPT_EN to enable the MAX_BURST ack quota that preempts a long-holding owner.
module wshb_rr_arbiter #(
  parameter int unsigned N_MASTERS = 3,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BURST = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_MASTERS-1:0]        m_cyc,
  input  logic [N_MASTERS-1:0]        m_stb,
  input  logic [N_MASTERS-1:0]        m_we,
  input  logic [N_MASTERS*AW-1:0]     m_adr,
  input  logic [N_MASTERS*DW/8-1:0]   m_sel,
  input  logic [N_MASTERS*DW-1:0]     m_dat_ms,
  output logic [N_MASTERS-1:0]        m_ack,
  output logic [DW-1:0]               m_dat_sm,
  output logic                        s_cyc,
  output logic                        s_stb,
  output logic                        s_we,
  output logic [AW-1:0]               s_adr,
  output logic [DW/8-1:0]             s_sel,
  output logic [DW-1:0]               s_dat_ms,
  input  logic                        s_ack,
  input  logic [DW-1:0]               s_dat_sm,
  output logic [N_MASTERS-1:0]        grant
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned OW = $clog2(N_MASTERS);

  // Reject unsupported configurations at elaboration.
  if (N_MASTERS < 2 || N_MASTERS > 8 || MAX_BURST < 1) begin : g_bad_cfg
    $error("wshb_rr_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_HANDOVER} state_t;

  state_t               r_state, w_state_nxt;
  logic [OW-1:0]        r_owner, w_owner_nxt;
  logic [OW-1:0]        r_last_owner, w_last_owner_nxt;
  logic [N_MASTERS-1:0] r_grant, w_grant_nxt;
  logic                 w_arb_valid;
  logic [OW-1:0]        w_arb_idx;
  logic                 w_own_cyc;
  logic                 w_preempt;

  // Round-robin pick: first requester after last_owner, wrapping modulo N_MASTERS.
  always_comb begin
    logic [OW-1:0] v_idx;
    v_idx       = '0;
    w_arb_valid = 1'b0;
    w_arb_idx   = '0;
    for (int unsigned k = N_MASTERS; k >= 1; k--) begin
      v_idx = OW'((32'(r_last_owner) + k) % N_MASTERS);
      if (m_cyc[v_idx]) begin
        w_arb_valid = 1'b1;
        w_arb_idx   = v_idx;
      end
    end
  end

  // Grant is one-hot only in BUSY, so masking with it both selects and gates the owner.
  assign w_own_cyc = |(m_cyc & r_grant);
  assign s_cyc     = w_own_cyc;
  assign s_stb     = w_own_cyc & (|(m_stb & r_grant));
  assign m_ack     = r_grant & {N_MASTERS{s_ack}};
  assign m_dat_sm  = s_dat_sm;
  assign grant     = r_grant;

  always_comb begin
    s_we     = 1'b0;
    s_adr    = '0;
    s_sel    = '0;
    s_dat_ms = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (r_grant[i]) begin
        s_we     = m_we[i];
        s_adr    = m_adr[i*AW +: AW];
        s_sel    = m_sel[i*SW +: SW];
        s_dat_ms = m_dat_ms[i*DW +: DW];
      end
    end
  end

`ifdef WSHB_ARB_PREEMPT_EN
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  logic [CW-1:0] r_burst_cnt, w_burst_nxt;

  // Acks taken by the current owner, saturating; cleared whenever the bus is not owned.
  always_comb begin
    w_burst_nxt = r_burst_cnt;
    if (r_state != ST_BUSY) begin
      w_burst_nxt = '0;
    end else if (s_ack && (r_burst_cnt != CW'(MAX_BURST))) begin
      w_burst_nxt = r_burst_cnt + CW'(1);
    end
  end

  assign w_preempt = w_own_cyc && s_ack && (r_burst_cnt >= CW'(MAX_BURST - 1))
                     && (|(m_cyc & ~r_grant));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_burst_cnt <= '0;
    else        r_burst_cnt <= w_burst_nxt;
  end
`else
  assign w_preempt = 1'b0;
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    w_grant_nxt      = r_grant;
    case (r_state)
      ST_IDLE, ST_HANDOVER: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        if (w_arb_valid) begin
          w_state_nxt = ST_BUSY;
          w_owner_nxt = w_arb_idx;
          w_grant_nxt = N_MASTERS'(1) << w_arb_idx;
        end
      end
      ST_BUSY: begin
        if (!w_own_cyc || w_preempt) begin
          w_state_nxt      = ST_HANDOVER;
          w_grant_nxt      = '0;
          w_last_owner_nxt = r_owner;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_last_owner <= OW'(N_MASTERS - 1);
      r_grant      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_grant      <= w_grant_nxt;
    end
  end

endmodule

// File: doc/wshb_rr_arbiter.md
Name: wshb_rr_arbiter

Overview:
- N-master to 1-slave Wishbone classic arbiter and multiplexer for the shared SDRAM port. Masters are the pattern generator, the VGA frame reader and any added DMA/blitter.
- Round-robin arbitration gives fair, deterministic sharing.
- Optional burst quota preempts a master that holds the bus too long.
- Sits between the requesting masters and the SDRAM controller's Wishbone slave port.

Parameters:
N_MASTERS, 3, number of requesting masters (2..8)
AW, 32, address width
DW, 32, data width; sel width is DW/8
MAX_BURST, 64, acks granted to one owner before preemption is allowed (only with the optional feature; >=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
m_cyc  in  N_MASTERS  per-master cyc; also that master's request
m_stb  in  N_MASTERS  per-master stb
m_we  in  N_MASTERS  per-master we
m_adr  in  N_MASTERS*AW  packed addresses, master i at [i*AW +: AW]
m_sel  in  N_MASTERS*DW/8  packed byte selects
m_dat_ms  in  N_MASTERS*DW  packed write data
m_ack  out  N_MASTERS  per-master ack
m_dat_sm  out  DW  read data, broadcast to all masters
s_cyc  out  1  to slave
s_stb  out  1  to slave
s_we  out  1  to slave
s_adr  out  AW  to slave
s_sel  out  DW/8  to slave
s_dat_ms  out  DW  to slave
s_ack  in  1  from slave
s_dat_sm  in  DW  from slave
grant  out  N_MASTERS  one-hot current owner; all zero when no owner

Behaviour:
- Interface decided: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset: state=IDLE, grant=0, owner=0, last_owner=N_MASTERS-1 (master 0 has first priority), burst_cnt=0.
  - All s_* outputs 0, m_ack=0.
  - Reset asserted mid-transfer aborts at once; no ack is delivered.
- Registered state machine: IDLE, BUSY, HANDOVER.
- IDLE:
  - s_cyc=s_stb=0.
  - If any m_cyc is high, select the first requester scanning from last_owner+1 upward with wrap-around.
  - Register it as owner, set grant, go to BUSY next cycle. Grant latency is 1 cycle from m_cyc rise.
- BUSY:
  - All s_* outputs are the combinational mux of the owner's signals.
  - m_ack[owner]=s_ack; every other m_ack=0.
  - m_dat_sm=s_dat_sm unconditionally.
  - burst_cnt increments on each s_ack; it saturates at MAX_BURST and clears on ownership change.
- BUSY to HANDOVER: when m_cyc[owner] is 0.
  - The owner's stb is ignored once its cyc is low.
  - last_owner is set to owner.
- HANDOVER: exactly 1 cycle.
  - s_cyc=s_stb=0, grant=0, all m_ack=0. Guarantees the slave sees each master's cycle as separate.
  - Arbitration runs as in IDLE: requester present -> BUSY with the new owner; none -> IDLE.
- Back-to-back requests from the same sole master: still 1 HANDOVER cycle between its cycles.
- Non-owner masters simply wait: cyc held, ack 0, no timeout.
- Width rules:
  - owner index is clog2(N_MASTERS) bits.
  - burst_cnt is clog2(MAX_BURST+1) bits.
  - Round-robin wrap uses modulo N_MASTERS for non-power-of-2 N.

Optional Feature:
- Macro: WSHB_ARB_PREEMPT_EN
- Defined (burst quota enabled):
  - In BUSY, if the owner's cyc is still high, an s_ack arrives that brings burst_cnt to MAX_BURST, and at least one other m_cyc is high: go to HANDOVER.
  - That ack is delivered to the owner normally.
  - The preempted master keeps cyc high, receives no ack and stalls. It re-enters round-robin as a normal pending requester.
  - If the owner drops cyc in the same cycle, this is treated as a normal release.
  - If no other requester is pending, the owner keeps the bus and burst_cnt stays saturated. Preemption happens at the next ack when a requester appears.
- Undefined: no quota. The owner holds the bus until it drops cyc; burst_cnt logic is removed.

Test Plan:
- Reset with all m_cyc=0 -> s_cyc=0, grant=0, m_ack=0; release rst_n while m_cyc=3'b111 -> 1 cycle later grant=3'b001 and s_adr=m_adr[0].
- Master 1 runs a 4-transfer read (slave acks every cycle, s_dat_sm=0xA5A50000+k) then drops cyc -> m_ack[1] pulses 4 times, m_dat_sm matches, exactly 1 HANDOVER cycle with s_cyc=0, then IDLE.
- All three masters hold cyc continuously, each dropping cyc after 2 transfers, then re-raising it -> grant order 001,010,100,001 with one HANDOVER cycle between each.
- Master 2 owns the bus while masters 0 and 1 raise cyc -> m_ack[0] and m_ack[1] stay 0 throughout; s_we and s_sel follow master 2 only.
- WSHB_ARB_PREEMPT_EN defined, MAX_BURST=4: master 0 requests 10 writes, master 1 pending -> after 4th ack go to HANDOVER, master 1 granted; master 0 resumes later with its remaining 6 writes; no ack lost or duplicated.
- Assert rst_n=0 mid-transfer with s_ack pending -> all outputs 0 immediately (asynchronously); after release, master 0 has first priority.
